// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one imem request at a time and buffers
// returned words for decode. Define FETCH_ALIGN_CHK_EN to halt on odd redirect targets.
module pc_fetch_unit #(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] next_pc,
  input  logic        halt,
  output logic [15:0] pc_out,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  input  logic        inst_ready,
  output logic        halted,
  output logic        misalign
);

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam logic [CntW-1:0] Depth = CntW'(BUF_DEPTH);

  typedef enum logic [1:0] {StFetch, StWait, StHalted} state_e;

  state_e          state_q;
  logic [15:0]     pc_q, addr_q, tag_q;
  logic            req_q, squash_q;
  logic [15:0]     fifo_inst_q [BUF_DEPTH];
  logic [15:0]     fifo_pc_q   [BUF_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q, count_d;

  logic        gnt_fire, rsp_fire, push, pop;
  logic        halt_take, redir_take, misalign_hit;
  logic [15:0] target;

  always_comb begin
`ifdef FETCH_ALIGN_CHK_EN
    target       = next_pc;
    misalign_hit = redirect & next_pc[0];
`else
    target       = next_pc & 16'hFFFE;
    misalign_hit = 1'b0;
`endif
    halt_take  = (state_q != StHalted) & (halt | misalign_hit);
    redir_take = (state_q != StHalted) & redirect & ~halt_take;
    gnt_fire   = (state_q == StFetch) & req_q & imem_gnt;
    rsp_fire   = (state_q == StWait) & imem_rvalid;
    // A response landing together with a redirect/halt belongs to the old stream.
    push       = rsp_fire & ~squash_q & ~redir_take & ~halt_take;
    pop        = (count_q != '0) & inst_ready;
    count_d    = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFetch;
      pc_q        <= '0;
      addr_q      <= '0;
      tag_q       <= '0;
      req_q       <= 1'b0;
      squash_q    <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      fifo_inst_q <= '{default: '0};
      fifo_pc_q   <= '{default: '0};
    end else begin
      if (push) begin
        fifo_inst_q[wr_ptr_q] <= imem_rdata;
        fifo_pc_q[wr_ptr_q]   <= tag_q;
      end
      if (halt_take) begin
        state_q  <= StHalted;
        req_q    <= 1'b0;
        squash_q <= 1'b0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else if (redir_take) begin
        pc_q     <= target;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
        if (gnt_fire || (state_q == StWait && !rsp_fire)) begin
          // Wait out the in-flight response before re-issuing.
          state_q  <= StWait;
          squash_q <= 1'b1;
          req_q    <= 1'b0;
        end else begin
          state_q  <= StFetch;
          squash_q <= 1'b0;
          req_q    <= 1'b1;
          addr_q   <= target;
        end
      end else begin
        count_q <= count_d;
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        case (state_q)
          StFetch: begin
            if (gnt_fire) begin
              state_q <= StWait;
              pc_q    <= pc_q + 16'd2;
              tag_q   <= pc_q;
              req_q   <= 1'b0;
            end else begin
              req_q  <= (count_d < Depth);
              addr_q <= pc_q;
            end
          end
          StWait: begin
            if (rsp_fire) begin
              state_q  <= StFetch;
              squash_q <= 1'b0;
              req_q    <= (count_d < Depth);
              addr_q   <= pc_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FETCH_ALIGN_CHK_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (misalign_hit && state_q != StHalted) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign pc_out     = pc_q;
  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = (count_q != '0);
  assign inst       = fifo_inst_q[rd_ptr_q];
  assign inst_pc    = fifo_pc_q[rd_ptr_q];
  assign halted     = (state_q == StHalted);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus random traffic against a queue-based
// model of the fetch stream.
module tb_pc_fetch_unit;

  localparam int unsigned Depth = 2;
`ifdef FETCH_ALIGN_CHK_EN
  localparam bit AlignChk = 1'b1;
`else
  localparam bit AlignChk = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redirect, halt, imem_gnt, imem_rvalid, inst_ready;
  logic [15:0] next_pc, imem_rdata;
  logic [15:0] pc_out, imem_addr, inst, inst_pc;
  logic        imem_req, inst_valid, halted, misalign;

  pc_fetch_unit #(.BUF_DEPTH(Depth)) dut (
    .clk        (clk),
    .rst        (rst),
    .redirect   (redirect),
    .next_pc    (next_pc),
    .halt       (halt),
    .pc_out     (pc_out),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .halted     (halted),
    .misalign   (misalign)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Memory behaviour knobs and state.
  int unsigned gnt_pct  = 100;
  int unsigned spur_pct = 0;
  int unsigned lat_min  = 1;
  int unsigned lat_max  = 1;
  logic [15:0] key      = 16'h0000;
  logic        mem_pend = 1'b0;
  logic [15:0] mem_addr = 16'h0000;
  int unsigned mem_wait = 0;

  // Reference model of the fetch stream.
  typedef struct {
    logic [15:0] pc;
    logic [15:0] data;
  } ent_t;
  ent_t        m_q[$];
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_tag = 16'h0000;
  bit          m_known = 1'b0;
  bit          m_fresh = 1'b0;
  bit          m_out = 1'b0;
  bit          m_squash = 1'b0;
  bit          m_halted = 1'b0;
  bit          m_misalign = 1'b0;

  logic [15:0] grant_log[$];
  logic [15:0] acc_pc_log[$];
  int          acc_cyc_log[$];
  int          cyc = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic grant, rsp, pop, odd, req_exp;
    imem_rvalid = mem_pend && (mem_wait == 0);
    imem_rdata  = imem_rvalid ? (mem_addr ^ key) : 16'($urandom);
    if (!mem_pend && !m_out && $urandom_range(99) < spur_pct) imem_rvalid = 1'b1;
    imem_gnt = !mem_pend && ($urandom_range(99) < gnt_pct);

    @(negedge clk);
    req_exp = m_known && !m_halted && !m_out && !m_fresh && (m_q.size() < Depth);
    if (m_known) begin
      check_eq("pc_out", pc_out, m_pc);
      check_eq("halted", 16'(halted), 16'(m_halted));
      check_eq("misalign", 16'(misalign), 16'(m_misalign));
      check_eq("inst_valid", 16'(inst_valid), 16'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        check_eq("inst_pc", inst_pc, m_q[0].pc);
        check_eq("inst", inst, m_q[0].data);
      end
      check_eq("imem_req", 16'(imem_req), 16'(req_exp));
      if (imem_req === 1'b1) check_eq("imem_addr", imem_addr, m_pc);
    end

    grant = (imem_req === 1'b1) && imem_gnt;
    rsp   = imem_rvalid;
    pop   = (inst_valid === 1'b1) && inst_ready;
    if (pop) begin
      acc_pc_log.push_back(inst_pc);
      acc_cyc_log.push_back(cyc);
    end
    if (mem_pend && mem_wait == 0) mem_pend = 1'b0;
    else if (mem_pend) mem_wait--;
    if (grant) begin
      grant_log.push_back(imem_addr);
      mem_pend = 1'b1;
      mem_addr = imem_addr;
      mem_wait = $urandom_range(lat_max - 1, lat_min - 1);
    end

    if (rst) begin
      m_known = 1'b1; m_fresh = 1'b1; m_pc = 16'h0000; m_q.delete();
      m_out = 1'b0; m_squash = 1'b0; m_halted = 1'b0; m_misalign = 1'b0;
    end else if (m_known) begin
      m_fresh = 1'b0;
      odd = AlignChk && redirect && next_pc[0];
      if (!m_halted && (halt || odd)) begin
        m_halted = 1'b1;
        if (odd) m_misalign = 1'b1;
        m_q.delete();
        m_out = 1'b0;
        m_squash = 1'b0;
      end else if (!m_halted && redirect) begin
        m_q.delete();
        m_pc = AlignChk ? next_pc : (next_pc & 16'hFFFE);
        m_squash = grant || (m_out && !rsp);
        m_out = m_squash;
      end else if (!m_halted) begin
        if (m_q.size() != 0 && inst_ready) void'(m_q.pop_front());
        if (m_out && rsp) begin
          if (!m_squash) m_q.push_back('{pc: m_tag, data: m_tag ^ key});
          m_out = 1'b0;
          m_squash = 1'b0;
        end
        if (grant) begin
          m_tag = m_pc;
          m_pc  = m_pc + 16'd2;
          m_out = 1'b1;
        end
      end
    end

    cyc++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    redirect = 1'b0;
    halt = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    bit found;
    int req_seen;
    rst = 1'b1; redirect = 1'b0; halt = 1'b0; next_pc = 16'h0000; inst_ready = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 16'h0000;
    do_reset();
    do_reset();
    check_eq("rst_pc_out", pc_out, 16'h0000);
    check_eq("rst_imem_addr", imem_addr, 16'h0000);
    check_eq("rst_inst", inst, 16'h0000);
    check_eq("rst_inst_pc", inst_pc, 16'h0000);
    check_eq("rst_imem_req", 16'(imem_req), 16'h0000);
    check_eq("rst_inst_valid", 16'(inst_valid), 16'h0000);
    check_eq("rst_halted", 16'(halted), 16'h0000);
    check_eq("rst_misalign", 16'(misalign), 16'h0000);

    // Streaming with single-cycle memory: one instruction every two cycles.
    acc_pc_log.delete(); acc_cyc_log.delete();
    for (int i = 0; i < 14; i++) tick();
    check_eq("t1_count", 16'(acc_pc_log.size() >= 3), 16'h0001);
    for (int i = 0; i < 3; i++)
      if (acc_pc_log.size() > i) check_eq("t1_pc", acc_pc_log[i], 16'(2 * i));
    for (int i = 1; i < 3; i++)
      if (acc_cyc_log.size() > i)
        check_eq("t1_gap", 16'(acc_cyc_log[i] - acc_cyc_log[i-1]), 16'd2);

    // Back-pressure fills the buffer, then drains in order.
    do_reset();
    inst_ready = 1'b0;
    grant_log.delete();
    for (int i = 0; i < 10; i++) tick();
    check_eq("t2_grants", 16'(grant_log.size()), 16'd2);
    check_eq("t2_req_low", 16'(imem_req), 16'h0000);
    inst_ready = 1'b1;
    acc_pc_log.delete(); grant_log.delete();
    for (int i = 0; i < 8; i++) tick();
    check_eq("t2_drain0", (acc_pc_log.size() > 0) ? acc_pc_log[0] : 16'hDEAD, 16'h0000);
    check_eq("t2_drain1", (acc_pc_log.size() > 1) ? acc_pc_log[1] : 16'hDEAD, 16'h0002);
    check_eq("t2_resume", (grant_log.size() > 0) ? grant_log[0] : 16'hDEAD, 16'h0004);

    // Redirect in the grant cycle of 0x0006.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_req && imem_addr == 16'h0006) begin
        found = 1'b1;
        redirect = 1'b1;
        next_pc = 16'h0100;
      end
      tick();
    end
    check_eq("t3_found", 16'(found), 16'h0001);
    acc_pc_log.delete();
    for (int i = 0; i < 8; i++) tick();
    check_eq("t3_first", (acc_pc_log.size() > 0) ? acc_pc_log[0] : 16'hDEAD, 16'h0100);

    // PC wraps at the top of the address space.
    redirect = 1'b1;
    next_pc = 16'hFFFC;
    tick();
    grant_log.delete();
    for (int i = 0; i < 14; i++) tick();
    check_eq("t4_g0", (grant_log.size() > 0) ? grant_log[0] : 16'hDEAD, 16'hFFFC);
    check_eq("t4_g1", (grant_log.size() > 1) ? grant_log[1] : 16'hDEAD, 16'hFFFE);
    check_eq("t4_g2", (grant_log.size() > 2) ? grant_log[2] : 16'hDEAD, 16'h0000);

    // Halt beats redirect while a request is outstanding.
    lat_min = 3; lat_max = 3;
    do_reset();
    grant_log.delete();
    for (int i = 0; i < 10; i++) if (grant_log.size() == 0) tick();
    check_eq("t5_granted", 16'(grant_log.size()), 16'd1);
    halt = 1'b1; redirect = 1'b1; next_pc = 16'h0200;
    tick();
    check_eq("t5_halted", 16'(halted), 16'h0001);
    check_eq("t5_pc", pc_out, 16'h0002);
    check_eq("t5_valid", 16'(inst_valid), 16'h0000);
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_req !== 1'b0) req_seen++;
    end
    check_eq("t5_no_req", 16'(req_seen), 16'h0000);
    do_reset();
    check_eq("t5_rst_pc", pc_out, 16'h0000);
    check_eq("t5_rst_halted", 16'(halted), 16'h0000);

    // Odd redirect target.
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    redirect = 1'b1;
    next_pc = 16'h0101;
    tick();
    grant_log.delete();
    for (int i = 0; i < 6; i++) tick();
`ifdef FETCH_ALIGN_CHK_EN
    check_eq("t6_misalign", 16'(misalign), 16'h0001);
    check_eq("t6_halted", 16'(halted), 16'h0001);
`else
    check_eq("t6_misalign", 16'(misalign), 16'h0000);
    check_eq("t6_fetch", (grant_log.size() > 0) ? grant_log[0] : 16'hDEAD, 16'h0100);
`endif

    // Random traffic against the model.
    gnt_pct = 60; spur_pct = 3; lat_min = 1; lat_max = 3;
    key = 16'($urandom);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      r = $urandom_range(999);
      inst_ready = ($urandom_range(99) < 70);
      rst = m_halted ? ($urandom_range(7) == 0) : ($urandom_range(499) == 0);
      redirect = (r < 40);
      halt = (r >= 40 && r < 45);
      next_pc = 16'($urandom);
      if ($urandom_range(9) != 0) next_pc[0] = 1'b0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
